// File: rtl/optimistic_output_channel_buffer_array_if.sv
`default_nettype none
// ============================================================================
// Module      : optimistic_output_channel_buffer_array_if
// Description : Bus bundle for the per-channel output FIFOs of one PE.
//               Groups the execute-stage enqueue port, the trigger-stage
//               in-flight mask and full status, and the network link drain
//               (valid/ready) side.
//               master : execute / trigger / link side (drives enqueues, ready)
//               slave  : buffer array side (drives heads, full, overflow)
// Revision    : 1.0 - initial release
// ============================================================================
interface optimistic_output_channel_buffer_array_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int WORD_WIDTH   = 32,
  parameter int TAG_WIDTH    = 3
);

  // Execute-stage enqueue port (one word broadcast to every strobed channel)
  logic [NUM_CHANNELS-1:0]            enqueue_oce;
  logic [TAG_WIDTH-1:0]               enqueue_tag;
  logic [WORD_WIDTH-1:0]              enqueue_data;

  // Channels that an instruction now in decode/execute is going to enqueue
  logic [NUM_CHANNELS-1:0]            downstream_oce;

  // Network link drain side
  logic [NUM_CHANNELS-1:0]            output_channel_valid;
  logic [NUM_CHANNELS*TAG_WIDTH-1:0]  output_channel_tag;
  logic [NUM_CHANNELS*WORD_WIDTH-1:0] output_channel_data;
  logic [NUM_CHANNELS-1:0]            output_channel_ready;

  // Status towards the trigger stage
  logic [NUM_CHANNELS-1:0]            output_channel_full_status;
  logic                               overflow_error;

  modport master (
    output enqueue_oce,
    output enqueue_tag,
    output enqueue_data,
    output downstream_oce,
    input  output_channel_valid,
    input  output_channel_tag,
    input  output_channel_data,
    output output_channel_ready,
    input  output_channel_full_status,
    input  overflow_error
  );

  modport slave (
    input  enqueue_oce,
    input  enqueue_tag,
    input  enqueue_data,
    input  downstream_oce,
    output output_channel_valid,
    output output_channel_tag,
    output output_channel_data,
    input  output_channel_ready,
    output output_channel_full_status,
    output overflow_error
  );

endinterface
`default_nettype wire

// File: rtl/optimistic_output_channel_buffer_array.sv
`default_nettype none
// ============================================================================
// Module      : optimistic_output_channel_buffer_array
// Description : Per-channel output FIFOs for one PE. The execute stage
//               enqueues results by OCE mask, network links drain heads with
//               valid/ready. The trigger stage gets a count-based full flag
//               that folds in enqueues still in flight downstream, without
//               crediting dequeues of the current cycle.
//               Optional build macro: TIA_OUTPUT_CHANNEL_BYPASS_EN
//                 defined   -> empty channel forwards an enqueue to its head
//                              in the same cycle (latency 0)
//                 undefined -> heads come from registered state only
//                              (latency 1)
// Revision    : 1.0 - initial release
// ============================================================================
module optimistic_output_channel_buffer_array #(
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH        = 4,   // power of two, >= 2
  parameter int WORD_WIDTH   = 32,
  parameter int TAG_WIDTH    = 3
) (
  input  wire logic                               clock,
  input  wire logic                               reset,  // async assert; release is synchronised upstream
  optimistic_output_channel_buffer_array_if.slave bus
);

  localparam int                 c_ptr_w     = $clog2(DEPTH);
  localparam int                 c_cnt_w     = c_ptr_w + 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w:0]   c_sum_depth = (c_cnt_w + 1)'(DEPTH);

  logic [NUM_CHANNELS-1:0]            w_valid;
  logic [NUM_CHANNELS*TAG_WIDTH-1:0]  w_tag;
  logic [NUM_CHANNELS*WORD_WIDTH-1:0] w_data;
  logic [NUM_CHANNELS-1:0]            w_full;
  logic [NUM_CHANNELS-1:0]            w_ovf;
  logic                               r_overflow;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan

    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [c_cnt_w-1:0]    r_count;
    logic [TAG_WIDTH-1:0]  r_tag_mem  [DEPTH];
    logic [WORD_WIDTH-1:0] r_data_mem [DEPTH];

    logic w_enq;
    logic w_rdy;
    logic w_has;
    logic w_at_full;
    logic w_bypass;
    logic w_deq;
    logic w_push;

    assign w_enq     = bus.enqueue_oce[i];
    assign w_rdy     = bus.output_channel_ready[i];
    assign w_has     = (r_count != '0);
    assign w_at_full = (r_count == c_cnt_depth);

`ifdef TIA_OUTPUT_CHANNEL_BYPASS_EN
    // An empty channel hands the incoming word straight to a ready link.
    assign w_bypass  = !w_has && w_enq && w_rdy;
`else
    assign w_bypass  = 1'b0;
`endif

    // Only stored words dequeue; a bypassed word never touches storage.
    assign w_deq     = w_has && w_rdy;
    // A full channel still accepts when its head leaves on the same edge.
    assign w_push    = w_enq && !w_bypass && (!w_at_full || w_deq);
    assign w_ovf[i]  = w_enq && w_at_full && !w_rdy;

    // Pointer and occupancy bookkeeping; storage itself is never reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_deq) begin
          r_head <= r_head + c_ptr_one;
        end
        if (w_push) begin
          r_tail <= r_tail + c_ptr_one;
        end
        if (w_push && !w_deq) begin
          r_count <= r_count + c_cnt_one;
        end else if (!w_push && w_deq) begin
          r_count <= r_count - c_cnt_one;
        end
      end
    end

    // Entry storage written at the tail on every accepted enqueue.
    always_ff @(posedge clock) begin
      if (w_push) begin
        r_tag_mem[r_tail]  <= bus.enqueue_tag;
        r_data_mem[r_tail] <= bus.enqueue_data;
      end
    end

`ifdef TIA_OUTPUT_CHANNEL_BYPASS_EN
    // Head is the stored entry, or the incoming word when the channel is
    // empty; held quiet while reset is asserted.
    assign w_valid[i] = !reset && (w_has || w_enq);
    assign w_tag[i*TAG_WIDTH +: TAG_WIDTH] =
      reset ? '0 : (w_has ? r_tag_mem[r_head] : (w_enq ? bus.enqueue_tag : '0));
    assign w_data[i*WORD_WIDTH +: WORD_WIDTH] =
      reset ? '0 : (w_has ? r_data_mem[r_head] : (w_enq ? bus.enqueue_data : '0));
`else
    // Head comes from registered state only; zero when empty so that
    // uninitialised storage never shows on the link.
    assign w_valid[i] = w_has;
    assign w_tag[i*TAG_WIDTH +: TAG_WIDTH]    = w_has ? r_tag_mem[r_head]  : '0;
    assign w_data[i*WORD_WIDTH +: WORD_WIDTH] = w_has ? r_data_mem[r_head] : '0;
`endif

    // Full when stored words plus the in-flight enqueue reach capacity;
    // a dequeue this cycle is deliberately not credited.
    assign w_full[i] = ({1'b0, r_count} + {{c_cnt_w{1'b0}}, bus.downstream_oce[i]})
                       >= c_sum_depth;

  end : g_chan

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (|w_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.output_channel_valid       = w_valid;
  assign bus.output_channel_tag         = w_tag;
  assign bus.output_channel_data        = w_data;
  assign bus.output_channel_full_status = w_full;
  assign bus.overflow_error             = r_overflow;

endmodule
`default_nettype wire
